// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding core-to-memory request bridge.
// The core posts a request and waits. The bridge captures the request,
// forwards aligned accesses to memory, and waits for mem_ack, giving up
// after a bounded number of cycles. It then returns a one-cycle
// core_ready pulse, with core_error set when the access failed.
// Optional feature: define MEM_BRIDGE_READ_BUFFER_EN to keep a one-entry
// buffer of the last successful read. An aligned read that hits the buffer
// completes without a memory access.
//
// Handshake semantics: the core holds core_valid high with a request while
// the bridge is IDLE; the request is accepted on the first rising edge in
// IDLE and core_valid is ignored until the bridge returns to IDLE. mem_req
// is held with stable address, write qualifier and data for every WAIT
// cycle, and mem_ack is only sampled in WAIT. core_ready is a single-cycle
// completion pulse and core_error qualifies it.
module mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_valid,
  input  logic                  core_write_enable,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic                  core_ready,
  output logic                  core_error,
  output logic                  mem_req,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ack,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter value on the last WAIT cycle that is still allowed to see an ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  buf_hit;
  logic [DATA_WIDTH-1:0] buf_rdata;

`ifdef MEM_BRIDGE_READ_BUFFER_EN
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  // Buffer hit check for an incoming aligned read in IDLE.
  always_comb begin
    buf_hit   = core_valid && !core_write_enable &&
                (core_address[1:0] == 2'b00) &&
                buf_valid_q && (core_address == buf_addr_q);
    buf_rdata = buf_data_q;
  end

  // Buffer update: fill on read completion, track writes to the same
  // address, and drop the entry on any timeout.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (state_q == WAIT) begin
      if (mem_ack) begin
        if (!we_q) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = addr_q;
          buf_data_d  = mem_data_in;
        end else if (buf_valid_q && (addr_q == buf_addr_q)) begin
          buf_data_d  = wdata_q;
        end
      end else if (cnt_q >= TMO_LAST) begin
        buf_valid_d = 1'b0;
      end
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  // No buffer in this build: every aligned read goes to memory.
  always_comb begin
    buf_hit   = 1'b0;
    buf_rdata = '0;
  end
`endif

  // Next-state and datapath capture for the IDLE/WAIT/RESP controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (core_valid) begin
          addr_d  = core_address;
          we_d    = core_write_enable;
          wdata_d = core_data_out;
          cnt_d   = 8'd0;
          if (core_address[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (buf_hit) begin
            err_d   = 1'b0;
            rdata_d = buf_rdata;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          err_d   = 1'b0;
          if (!we_q) rdata_d = mem_data_in;
          state_d = RESP;
        end else if (cnt_q >= TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    mem_req          = (state_q == WAIT);
    mem_write_enable = (state_q == WAIT) ? we_q : 1'b0;
    mem_address      = (state_q == WAIT) ? addr_q : '0;
    mem_data_out     = (state_q == WAIT) ? wdata_q : '0;
    core_ready       = (state_q == RESP);
    core_error       = (state_q == RESP) ? err_q : 1'b0;
    core_data_in     = rdata_q;
    state_dbg_o      = state_q;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width on both sides.
REQ-002 Parameter DATA_WIDTH, 32, word width on both sides.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum WAIT cycles before a request is aborted; legal range 1..255.
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous active-high reset
- core_valid  input  1  core request strobe
- core_write_enable  input  1  1 = write, 0 = read
- core_address  input  ADDR_WIDTH  request byte address
- core_data_out  input  DATA_WIDTH  write data from core
- core_data_in  output  DATA_WIDTH  read data to core
- core_ready  output  1  one-cycle completion pulse
- core_error  output  1  asserted with core_ready on misalignment or timeout
- mem_req  output  1  memory request, held until ack
- mem_write_enable  output  1  memory write qualifier
- mem_address  output  ADDR_WIDTH  memory address
- mem_data_out  output  DATA_WIDTH  memory write data
- mem_data_in  input  DATA_WIDTH  memory read data
- mem_ack  input  1  memory completion, sampled only in WAIT

Function
REQ-006 The block SHALL implement states IDLE, WAIT, RESP.
REQ-007 In IDLE with core_valid=1, the block SHALL capture address, write_enable and write data in that cycle; aligned (address[1:0]=0) -> WAIT; misaligned -> RESP with error, no mem_req.
REQ-008 In WAIT, mem_req SHALL be 1 and mem_address/mem_write_enable/mem_data_out SHALL be driven from captured registers, stable until exit.
REQ-009 In WAIT with mem_ack=1, the block SHALL go to RESP; for reads, it SHALL load mem_data_in into core_data_in.
REQ-010 A saturating wait counter SHALL count WAIT cycles; after TIMEOUT_CYCLES cycles without ack, it SHALL go to RESP with error and core_data_in=0.
REQ-011 mem_ack in the same cycle as timeout expiry SHALL win: normal completion, no error.
REQ-012 In RESP, core_ready SHALL be 1 for exactly one cycle with core_error per the cause; next state IDLE.
REQ-013 core_valid SHALL be ignored in WAIT and RESP; mem_ack SHALL be ignored in IDLE and RESP.
REQ-014 Minimum latency SHALL be valid at cycle 0, mem_req at cycle 1, ack at cycle 1, core_ready at cycle 2; each extra wait cycle adds one.
REQ-015 core_data_in SHALL hold its value except on read completion, timeout, or buffer hit; writes SHALL NOT change it.
REQ-016 mem_req, mem_write_enable, mem_address and mem_data_out SHALL be 0 outside WAIT.

Reset
REQ-017 Reset SHALL immediately force state IDLE, counter 0, buffer invalid, and all outputs 0, including mid-WAIT (mem_req drops without waiting for ack).
REQ-018 After deassertion, the first core_valid SHALL be accepted normally.

Configuration
REQ-019 With MEM_BRIDGE_READ_BUFFER_EN defined, the block SHALL keep a one-entry buffer of address, data and valid from the last successful read.
REQ-020 With the macro defined, an aligned read hitting the buffer in IDLE SHALL go directly to RESP with buffered data, no mem_req (latency 1).
REQ-021 With the macro defined, a successful write to the buffered address SHALL update buffered data to the written value; any timeout SHALL invalidate the buffer.
REQ-022 Without the macro, no buffer SHALL exist and every aligned read SHALL go to memory.

Verification
REQ-023 Read 0x100, ack on 2nd WAIT cycle, mem_data_in=0xDEADBEEF -> mem_req cycles 1-2, core_ready cycle 3, core_data_in=0xDEADBEEF, error 0.
REQ-024 Write 0x200 data 0x12345678, immediate ack -> mem_write_enable=1, mem_data_out=0x12345678, ready cycle 2, core_data_in unchanged.
REQ-025 Read 0x102 -> no mem_req, core_ready and core_error in cycle 1.
REQ-026 Read 0x300, no ack, TIMEOUT_CYCLES=16 -> mem_req 16 cycles, then ready+error, core_data_in=0; ack on 16th cycle -> no error.
REQ-027 Reset asserted mid-WAIT -> mem_req 0 same cycle, IDLE; next read completes normally.
REQ-028 With MEM_BRIDGE_READ_BUFFER_EN: read 0x100 twice -> second ready cycle 1, no mem_req; write 0x100=0x1 then read 0x100 -> 0x1 with no mem_req.
